// File: rtl/bip_run_ctrl.sv
// bip_run_ctrl -- run/debug sequencer for the BIP core.
//
// Decodes a byte command stream from the UART receiver:
//   'L' (0x4C) N_hi N_lo {w_hi w_lo}*N : load N words into program memory from address 0
//   'R' (0x52)                         : run until HLT, then report the PC
//   'S' (0x53)                         : single-step one instruction, then report the PC
//   'D' (0x44) a_hi a_lo               : read one data-memory word and report it
// Reports are two bytes, MSB first, over a valid/ready TX port.
//
// Optional feature macro: BIP_RUN_ABORT_EN
//   When defined, an ESC byte (0x1B) received during RUN stops the CPU in that
//   cycle and reports the PC exactly as HLT does.
//
// Ports:
//   i_clk       system clock
//   i_rst       synchronous active-low reset
//   i_rx_data   received byte
//   i_rx_valid  one-cycle strobe qualifying i_rx_data
//   i_opcode    opcode at the program-memory output (HLT = 0)
//   i_pc        current CPU program counter
//   i_dm_data   data-memory read data (1-cycle registered read)
//   i_tx_ready  UART TX accepts a byte
//   o_cpu_en    CPU advance enable
//   o_pm_wr_en  program-memory write strobe
//   o_pm_addr   program-memory write address
//   o_pm_data   program-memory write data
//   o_dm_sel    1 = this block drives the data-memory address
//   o_dm_addr   data-memory read address
//   o_tx_data   byte to transmit
//   o_tx_valid  o_tx_data is valid
//   o_busy      controller not idle
module bip_run_ctrl #(
    parameter int NB_OPCODE = 5,
    parameter int NB_ADDR   = 11,
    parameter int RAM_WIDTH = 16,
    parameter int NB_BYTE   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NB_BYTE-1:0]   i_rx_data,
    input  logic                 i_rx_valid,
    input  logic [NB_OPCODE-1:0] i_opcode,
    input  logic [NB_ADDR-1:0]   i_pc,
    input  logic [RAM_WIDTH-1:0] i_dm_data,
    input  logic                 i_tx_ready,
    output logic                 o_cpu_en,
    output logic                 o_pm_wr_en,
    output logic [NB_ADDR-1:0]   o_pm_addr,
    output logic [RAM_WIDTH-1:0] o_pm_data,
    output logic                 o_dm_sel,
    output logic [NB_ADDR-1:0]   o_dm_addr,
    output logic [NB_BYTE-1:0]   o_tx_data,
    output logic                 o_tx_valid,
    output logic                 o_busy
);

    localparam int NB_WORD = 2 * NB_BYTE;

    localparam logic [NB_BYTE-1:0] CMD_LOAD = 8'h4C;
    localparam logic [NB_BYTE-1:0] CMD_RUN  = 8'h52;
    localparam logic [NB_BYTE-1:0] CMD_STEP = 8'h53;
    localparam logic [NB_BYTE-1:0] CMD_DUMP = 8'h44;

    typedef enum logic [3:0] {
        IDLE,
        LD_CNT_HI,
        LD_CNT_LO,
        LD_HI,
        LD_LO,
        RUN,
        STEP,
        DA_HI,
        DA_LO,
        DM_WAIT,
        TX_HI,
        TX_LO
    } state_t;

    state_t state, state_nxt;

    logic [NB_BYTE-1:0]   hi_q;        // shared high-byte latch: count, PM word, DM address
    logic [NB_WORD-1:0]   cnt_q;       // words still to be written
    logic [NB_ADDR-1:0]   pm_addr_q;
    logic [NB_ADDR-1:0]   dm_addr_q;
    logic [RAM_WIDTH-1:0] tx_word_q;
    logic                 pc_snap_q;   // first TX_HI cycle after STEP reports the live PC

    logic [RAM_WIDTH-1:0] pc_ext;
    logic [NB_WORD-1:0]   rx_word;
    logic [NB_ADDR-1:0]   rx_dm_addr;
    logic                 esc_hit;
    logic                 run_stop;

    assign pc_ext     = RAM_WIDTH'(i_pc);
    assign rx_word    = {hi_q, i_rx_data};
    assign rx_dm_addr = NB_ADDR'(rx_word);

`ifdef BIP_RUN_ABORT_EN
    localparam logic [NB_BYTE-1:0] CMD_ESC = 8'h1B;
    assign esc_hit = i_rx_valid && (i_rx_data == CMD_ESC);
`else
    assign esc_hit = 1'b0;
`endif

    // HLT and ESC in the same cycle give the same response, so one stop term covers both.
    assign run_stop = (i_opcode == '0) || esc_hit;

    assign o_pm_addr = pm_addr_q;
    assign o_busy    = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        o_cpu_en   = 1'b0;
        o_pm_wr_en = 1'b0;
        o_pm_data  = '0;
        o_dm_sel   = 1'b0;
        o_dm_addr  = dm_addr_q;
        o_tx_valid = 1'b0;
        o_tx_data  = '0;

        case (state)
            IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_LOAD: state_nxt = LD_CNT_HI;
                        CMD_RUN:  state_nxt = RUN;
                        CMD_STEP: state_nxt = STEP;
                        CMD_DUMP: state_nxt = DA_HI;
                        default:  state_nxt = IDLE;
                    endcase
                end
            end
            LD_CNT_HI: if (i_rx_valid) state_nxt = LD_CNT_LO;
            LD_CNT_LO: begin
                if (i_rx_valid) state_nxt = (rx_word == '0) ? IDLE : LD_HI;
            end
            LD_HI: if (i_rx_valid) state_nxt = LD_LO;
            LD_LO: begin
                if (i_rx_valid) begin
                    o_pm_wr_en = 1'b1;
                    o_pm_data  = RAM_WIDTH'(rx_word);
                    state_nxt  = (cnt_q == NB_WORD'(1)) ? IDLE : LD_HI;
                end
            end
            RUN: begin
                if (run_stop) begin
                    state_nxt = TX_HI;
                end else begin
                    o_cpu_en = 1'b1;
                end
            end
            STEP: begin
                o_cpu_en  = 1'b1;
                state_nxt = TX_HI;
            end
            DA_HI: if (i_rx_valid) state_nxt = DA_LO;
            DA_LO: begin
                // Address goes out in the arrival cycle so the registered DM read
                // is ready by the end of DM_WAIT.
                if (i_rx_valid) begin
                    o_dm_sel  = 1'b1;
                    o_dm_addr = rx_dm_addr;
                    state_nxt = DM_WAIT;
                end
            end
            DM_WAIT: begin
                o_dm_sel  = 1'b1;
                state_nxt = TX_HI;
            end
            TX_HI: begin
                o_tx_valid = 1'b1;
                o_tx_data  = pc_snap_q ? pc_ext[RAM_WIDTH-1 -: NB_BYTE]
                                       : tx_word_q[RAM_WIDTH-1 -: NB_BYTE];
                if (i_tx_ready) state_nxt = TX_LO;
            end
            TX_LO: begin
                o_tx_valid = 1'b1;
                o_tx_data  = tx_word_q[NB_BYTE-1:0];
                if (i_tx_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            hi_q      <= '0;
            cnt_q     <= '0;
            pm_addr_q <= '0;
            dm_addr_q <= '0;
            tx_word_q <= '0;
            pc_snap_q <= 1'b0;
        end else begin
            case (state)
                LD_CNT_HI, LD_HI, DA_HI: begin
                    if (i_rx_valid) hi_q <= i_rx_data;
                end
                LD_CNT_LO: begin
                    if (i_rx_valid) begin
                        cnt_q     <= rx_word;
                        pm_addr_q <= '0;
                    end
                end
                LD_LO: begin
                    if (i_rx_valid) begin
                        pm_addr_q <= pm_addr_q + NB_ADDR'(1);
                        cnt_q     <= cnt_q - NB_WORD'(1);
                    end
                end
                RUN: begin
                    if (run_stop) tx_word_q <= pc_ext;
                end
                STEP: pc_snap_q <= 1'b1;
                DA_LO: begin
                    if (i_rx_valid) dm_addr_q <= rx_dm_addr;
                end
                DM_WAIT: tx_word_q <= i_dm_data;
                TX_HI: begin
                    // PC is frozen in TX states, so snapshotting here equals the post-step PC.
                    if (pc_snap_q) begin
                        tx_word_q <= pc_ext;
                        pc_snap_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bip_run_ctrl.sv
module tb_bip_run_ctrl;

    localparam int NB_OPCODE = 5;
    localparam int NB_ADDR   = 11;
    localparam int RAM_WIDTH = 16;
    localparam int NB_BYTE   = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NB_BYTE-1:0]   rx_data;
    logic                 rx_valid;
    logic [NB_OPCODE-1:0] opcode;
    logic [NB_ADDR-1:0]   pc;
    logic [RAM_WIDTH-1:0] dm_q;
    logic                 tx_ready;
    logic                 cpu_en;
    logic                 pm_wr_en;
    logic [NB_ADDR-1:0]   pm_addr;
    logic [RAM_WIDTH-1:0] pm_data;
    logic                 dm_sel;
    logic [NB_ADDR-1:0]   dm_addr;
    logic [NB_BYTE-1:0]   tx_data;
    logic                 tx_valid;
    logic                 busy;

    always #5 clk = ~clk;

    bip_run_ctrl #(
        .NB_OPCODE(NB_OPCODE),
        .NB_ADDR  (NB_ADDR),
        .RAM_WIDTH(RAM_WIDTH),
        .NB_BYTE  (NB_BYTE)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_rx_data (rx_data),
        .i_rx_valid(rx_valid),
        .i_opcode  (opcode),
        .i_pc      (pc),
        .i_dm_data (dm_q),
        .i_tx_ready(tx_ready),
        .o_cpu_en  (cpu_en),
        .o_pm_wr_en(pm_wr_en),
        .o_pm_addr (pm_addr),
        .o_pm_data (pm_data),
        .o_dm_sel  (dm_sel),
        .o_dm_addr (dm_addr),
        .o_tx_data (tx_data),
        .o_tx_valid(tx_valid),
        .o_busy    (busy)
    );

    // ---------------- environment model: PM, CPU PC, DM ----------------
    logic [RAM_WIDTH-1:0] pm [0:2047];
    logic [NB_ADDR-1:0]   wq_a [$];
    logic [RAM_WIDTH-1:0] wq_d [$];
    logic                 pc_set;
    logic [NB_ADDR-1:0]   pc_set_val;
    logic                 fill_mode;
    int                   en_cnt = 0;
    int                   sel_cnt = 0;
    int                   sel_bad = 0;
    logic [NB_ADDR-1:0]   esc_pc = '0;
    logic                 esc_en = 1'b0;

    logic [RAM_WIDTH-1:0] pm_word;
    assign pm_word = pm[pc];
    assign opcode  = fill_mode ? 5'h01 : pm_word[15:11];

    always @(posedge clk) begin
        if (pm_wr_en) begin
            pm[pm_addr] <= pm_data;
            wq_a.push_back(pm_addr);
            wq_d.push_back(pm_data);
        end
        if (pc_set) pc <= pc_set_val;
        else if (cpu_en) pc <= pc + 1'b1;
        dm_q <= (dm_addr == 11'h07A) ? 16'hBEEF : {5'b0, dm_addr};
        if (cpu_en) en_cnt = en_cnt + 1;
        if (dm_sel) begin
            sel_cnt = sel_cnt + 1;
            if (dm_addr != 11'h07A) sel_bad = sel_bad + 1;
        end
        if (rx_valid && rx_data == 8'h1B && busy) begin
            esc_pc = pc;
            esc_en = cpu_en;
        end
    end

    // ---------------- checking helpers ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic recv(output logic ok, output logic [7:0] b);
        ok = 1'b0;
        b  = '0;
        for (int i = 0; i < 200; i++) begin
            if (tx_valid) begin
                b        = tx_data;
                tx_ready = 1'b1;
                @(negedge clk);
                #1;
                tx_ready = 1'b0;
                ok       = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_pc(input logic [NB_ADDR-1:0] v);
        pc_set     = 1'b1;
        pc_set_val = v;
        @(negedge clk);
        #1;
        pc_set = 1'b0;
    endtask

    task automatic expect_report(input string name, input logic [15:0] exp);
        logic       ok;
        logic [7:0] b;
        recv(ok, b);
        check({name, "_hi"}, {23'h0, ok, b}, {23'h0, 1'b1, exp[15:8]});
        recv(ok, b);
        check({name, "_lo"}, {23'h0, ok, b}, {23'h0, 1'b1, exp[7:0]});
    endtask

    function automatic logic [31:0] all_outs();
        return {cpu_en, pm_wr_en, |pm_addr, |pm_data, dm_sel, |dm_addr, |tx_data, tx_valid, busy};
    endfunction

    typedef struct {
        logic [7:0] rx;
        logic       busy;
    } dec_vec_t;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        dec_vec_t dv [10];
        int base;
        int en_base;

        dv[0] = '{8'h00, 1'b0};
        dv[1] = '{8'h1B, 1'b0};
        dv[2] = '{8'h6C, 1'b0};
        dv[3] = '{8'hFF, 1'b0};
        dv[4] = '{8'h4D, 1'b0};
        dv[5] = '{8'h72, 1'b0};
        dv[6] = '{8'h4C, 1'b1};
        dv[7] = '{8'h00, 1'b1};
        dv[8] = '{8'h00, 1'b0};   // N = 0 returns to IDLE
        dv[9] = '{8'h41, 1'b0};

        rst        = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = '0;
        tx_ready   = 1'b0;
        pc_set     = 1'b1;
        pc_set_val = '0;
        fill_mode  = 1'b0;
        cycles(3);
        check("reset_outputs", all_outs(), 32'h0);
        rst    = 1'b1;
        pc_set = 1'b0;
        cycles(1);

        // Decode table: ignored bytes stay idle, 'L' with N = 0 returns to idle.
        base = wq_a.size();
        for (int i = 0; i < 10; i++) begin
            send(dv[i].rx);
            check($sformatf("decode_busy_%0d", i), {31'h0, busy}, {31'h0, dv[i].busy});
            check($sformatf("decode_cpu_en_%0d", i), {31'h0, cpu_en}, 32'h0);
        end
        check("decode_no_writes", wq_a.size() - base, 32'h0);

        // Reset mid-load: one word written, second word's high byte pending.
        base = wq_a.size();
        send(8'h4C); send(8'h00); send(8'h03); send(8'h12); send(8'h34); send(8'h56);
        rst = 1'b0;
        cycles(1);
        check("midload_reset_outputs", all_outs(), 32'h0);
        rst = 1'b1;
        send(8'h78);
        check("midload_idle_after", {31'h0, busy}, 32'h0);
        check("midload_write_count", wq_a.size() - base, 32'd1);
        if (wq_a.size() > base) begin
            check("midload_addr0", {21'h0, wq_a[base]}, 32'h0);
            check("midload_data0", {16'h0, wq_d[base]}, 32'h1234);
        end

        // Load two words.
        base = wq_a.size();
        send(8'h4C); send(8'h00); send(8'h02);
        send(8'hAB); send(8'hCD); send(8'h12); send(8'h34);
        check("load_write_count", wq_a.size() - base, 32'd2);
        if (wq_a.size() >= base + 2) begin
            check("load_addr0", {21'h0, wq_a[base]}, 32'h0);
            check("load_data0", {16'h0, wq_d[base]}, 32'hABCD);
            check("load_addr1", {21'h0, wq_a[base+1]}, 32'h1);
            check("load_data1", {16'h0, wq_d[base+1]}, 32'h1234);
        end
        check("load_idle", {31'h0, busy}, 32'h0);

        // Program: opcode 1 at 0..4, HLT at 5.
        send(8'h4C); send(8'h00); send(8'h06);
        for (int i = 0; i < 5; i++) begin
            send(8'h08); send(8'h00);
        end
        send(8'h00); send(8'h00);
        check("prog_pm5", {16'h0, pm[5]}, 32'h0);

        set_pc(11'd0);
        en_base = en_cnt;
        send(8'h52);
        expect_report("run_pc", 16'h0005);
        check("run_en_cycles", en_cnt - en_base, 32'd5);
        check("run_idle", {31'h0, busy}, 32'h0);

        // HLT already present on entry: no enabled cycles.
        set_pc(11'd5);
        en_base = en_cnt;
        send(8'h52);
        expect_report("run_hlt_entry_pc", 16'h0005);
        check("run_hlt_entry_en", en_cnt - en_base, 32'd0);

        // Single step from PC 3.
        set_pc(11'd3);
        en_base = en_cnt;
        send(8'h53);
        expect_report("step_pc", 16'h0004);
        check("step_en_cycles", en_cnt - en_base, 32'd1);

        // Dump with TX back-pressure.
        tx_ready = 1'b0;
        base     = sel_cnt;
        send(8'h44); send(8'h00); send(8'h7A);
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            check($sformatf("dump_hold_%0d", i), {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'hBE});
        end
        expect_report("dump_word", 16'hBEEF);
        check("dump_sel_cycles", sel_cnt - base, 32'd2);
        check("dump_sel_addr_bad", sel_bad, 32'd0);

        // Endless program, ESC during RUN.
        fill_mode = 1'b1;
        set_pc(11'd0);
        en_base = en_cnt;
        send(8'h52);
        cycles(20);
        send(8'h1B);
`ifdef BIP_RUN_ABORT_EN
        check("abort_en_in_esc_cycle", {31'h0, esc_en}, 32'h0);
        check("abort_esc_pc", {21'h0, esc_pc}, 32'd20);
        expect_report("abort_pc", 16'h0014);
        check("abort_en_cycles", en_cnt - en_base, 32'd20);
        check("abort_idle", {31'h0, busy}, 32'h0);
`else
        cycles(5);
        check("noabort_busy", {31'h0, busy}, 32'h1);
        check("noabort_cpu_en", {31'h0, cpu_en}, 32'h1);
        check("noabort_pc", {21'h0, pc}, 32'd26);
        rst = 1'b0;
        cycles(1);
        rst = 1'b1;
        check("noabort_reset_idle", all_outs(), 32'h0);
`endif
        fill_mode = 1'b0;

        // Reset with a pending TX byte drops it.
        tx_ready = 1'b0;
        send(8'h53);
        cycles(2);
        check("pending_tx_valid", {31'h0, tx_valid}, 32'h1);
        rst = 1'b0;
        cycles(1);
        check("pending_tx_dropped", all_outs(), 32'h0);
        rst = 1'b1;
        cycles(2);
        check("pending_tx_stays_idle", {30'h0, tx_valid, busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bip_run_ctrl.md
Name: bip_run_ctrl

Overview:
- Run/debug sequencer for the BIP core. It takes a byte command stream from the UART receiver and performs one of four actions: load program memory, run until HLT, single-step, or read back data memory.
- It owns the CPU clock-enable, the program-memory write port, and the data-memory address mux. Results go out over a byte-wide valid/ready TX port.
- It sits between the UART and the bips top, and is the only master of the core outside normal execution.

Parameters:
- NB_OPCODE, 5, opcode width (HLT = all zeros).
- NB_ADDR, 11, program-counter / PM address width.
- RAM_WIDTH, 16, instruction and data word width.
- NB_BYTE, 8, UART byte width.

Ports:
- i_clk  in  1  single system clock (the only clock).
- i_rst  in  1  synchronous, active-low reset.
- i_rx_data  in  NB_BYTE  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid.
- i_opcode  in  NB_OPCODE  opcode currently at the PM output.
- i_pc  in  NB_ADDR  current CPU program counter.
- i_dm_data  in  RAM_WIDTH  DM read data (1-cycle registered read).
- i_tx_ready  in  1  UART TX can accept a byte.
- o_cpu_en  out  1  CPU advance enable.
- o_pm_wr_en  out  1  PM write strobe.
- o_pm_addr  out  NB_ADDR  PM write address.
- o_pm_data  out  RAM_WIDTH  PM write data.
- o_dm_sel  out  1  1 = controller drives DM address.
- o_dm_addr  out  NB_ADDR  DM read address.
- o_tx_data  out  NB_BYTE  byte to transmit.
- o_tx_valid  out  1  o_tx_data is valid.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset:
  - i_rst low at a rising edge forces state IDLE.
  - All outputs 0. Load counters, word and address registers cleared.
  - Reset applies mid-operation with no drain: a partially loaded PM keeps the words already written, and a pending TX byte is dropped.
- States: IDLE, LD_CNT_HI, LD_CNT_LO, LD_HI, LD_LO, RUN, STEP, DA_HI, DA_LO, DM_WAIT, TX_HI, TX_LO.
- IDLE decodes only on i_rx_valid:
  - 0x4C 'L' -> LD_CNT_HI.
  - 0x52 'R' -> RUN.
  - 0x53 'S' -> STEP.
  - 0x44 'D' -> DA_HI.
  - Any other byte is ignored and the state stays IDLE.
- Load:
  - LD_CNT_HI and LD_CNT_LO capture a 16-bit word count N, MSB byte first.
  - N = 0 -> IDLE. Otherwise pm address register = 0 -> LD_HI.
  - LD_HI latches the high byte.
  - In LD_LO, when a byte arrives, o_pm_wr_en = 1 for exactly that cycle, with o_pm_data = {hi, i_rx_data} and o_pm_addr = address register.
  - Next cycle: address +1 (wraps modulo 2^NB_ADDR) and remaining count -1. Remaining = 0 -> IDLE, else -> LD_HI.
  - N > 2^NB_ADDR overwrites from address 0 again.
- Run:
  - o_cpu_en = 1 combinationally while state = RUN and i_opcode != 0.
  - When i_opcode == 0 (HLT), o_cpu_en = 0 in that same cycle. Next state is TX_HI with tx word = zero-extended i_pc.
  - If HLT is already present on entry, there are zero enabled cycles.
- STEP:
  - o_cpu_en = 1 for exactly one cycle regardless of opcode.
  - Then tx word = zero-extended i_pc, sampled after the step (the cycle following STEP) -> TX_HI.
- Dump:
  - DA_HI and DA_LO capture the address, MSB first; bits above NB_ADDR are discarded.
  - o_dm_sel = 1 from DA_LO exit through DM_WAIT.
  - DM_WAIT lasts 1 cycle, then i_dm_data is captured into the tx word -> TX_HI.
- TX:
  - TX_HI: o_tx_valid = 1 with o_tx_data = word[15:8], held until i_tx_ready = 1 in the same cycle -> TX_LO.
  - TX_LO: same rule with word[7:0] -> IDLE.
  - o_tx_data is stable while valid and not ready.
- RX bytes arriving in RUN, STEP, DM_WAIT or the TX states are dropped, except as stated under Optional Feature.
- o_cpu_en is 0 in every state except RUN and STEP, so the CPU is frozen during load and dump.

Optional Feature:
- Macro: BIP_RUN_ABORT_EN.
- Defined: in RUN, i_rx_valid with byte 0x1B (ESC) forces o_cpu_en = 0 in that cycle. The controller then reports the PC as for HLT (TX_HI, then TX_LO, then IDLE). If HLT and ESC occur in the same cycle, it is treated as HLT (identical response).
- Not defined: 0x1B in RUN is ignored like every other byte, and RUN exits only on HLT.

Test Plan:
- Reset mid-load: send 4C 00 03 12 34, then pulse i_rst low -> all outputs 0, IDLE; PM addr 0 holds 0x1234 and nothing else is written.
- Load: send 4C 00 02 AB CD 12 34 -> two o_pm_wr_en pulses (addr 0 = 0xABCD, addr 1 = 0x1234), then o_busy = 0.
- Run: PM holds opcodes non-zero at 0..4 and HLT at 5; send 52 -> exactly 5 o_cpu_en cycles, then TX bytes 00, 05.
- Step: with PC = 3, send 53 -> one o_cpu_en cycle, then TX 00, 04.
- Dump with back-pressure: DM[0x07A] = 0xBEEF; send 44 00 7A with i_tx_ready low for 10 cycles -> o_tx_valid held with 0xBE, then 0xEF after ready; o_dm_addr = 0x07A while o_dm_sel = 1.
- Abort: with BIP_RUN_ABORT_EN defined, an endless program and 1B sent while in RUN -> o_cpu_en drops in the ESC cycle, then PC bytes are sent. Without the macro, RUN continues.
